// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int OP_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] data_1_i,
    input  logic [XLEN-1:0] data_2_i,
    input  logic [OP_W-1:0] md_op_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [2:0]          op_q, op_d;
    logic                a_neg_q, a_neg_d;
    logic                b_neg_q, b_neg_d;

    logic [2:0]      op3;
    logic            op_def, is_div, accept, special;
    logic            a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;

    logic [XLEN:0]     sum, shl;
    logic [XLEN+1:0]   diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nxt, quo, rem, fin_res;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt, mul_s;

    // Request decode: operand signs, magnitudes and the single-cycle cases
    always_comb begin
        op3      = md_op_i[2:0];
        op_def   = (md_op_i >> 3) == '0;
        is_div   = op3[2];
        accept   = valid_i && ready_o && !flush_i;
        a_neg    = data_1_i[XLEN-1] &&
                   (op3 inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_neg    = data_2_i[XLEN-1] &&
                   (op3 inside {OP_MULH, OP_DIV, OP_REM});
        a_mag    = a_neg ? -data_1_i : data_1_i;
        b_mag    = b_neg ? -data_2_i : data_2_i;
        div_zero = op_def && is_div && (data_2_i == '0);
        ovf      = op_def && (op3 == OP_DIV || op3 == OP_REM) &&
                   (data_1_i == MIN) && (data_2_i == '1);
        special  = !op_def || div_zero || ovf;
        spec_res = '0;
        if (!op_def)
            spec_res = '0;
        else if (div_zero)
            spec_res = op3[1] ? data_1_i : '1;
        else if (ovf)
            spec_res = op3[1] ? '0 : MIN;
    end

    // One iteration of shift-add / restoring divide plus final sign fix-up
    always_comb begin
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nxt = {sum, acc_q[XLEN-1:1]};
        shl     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff    = {1'b0, shl} - {2'b00, opnd_q};
        q_bit   = ~diff[XLEN+1];
        rem_nxt = q_bit ? diff[XLEN-1:0] : shl[XLEN-1:0];
        div_nxt = {rem_nxt, acc_q[XLEN-2:0], q_bit};
        acc_nxt = op_q[2] ? div_nxt : mul_nxt;
        mul_s   = (a_neg_q ^ b_neg_q) ? -acc_nxt : acc_nxt;
        quo     = acc_nxt[XLEN-1:0];
        rem     = acc_nxt[2*XLEN-1:XLEN];
        fin_res = '0;
        unique case (op_q)
            OP_MUL:    fin_res = mul_s[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fin_res = mul_s[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:   fin_res = (a_neg_q ^ b_neg_q) ? -quo : quo;
            OP_REM,
            OP_REMU:   fin_res = a_neg_q ? -rem : rem;
            default:   fin_res = '0;
        endcase
    end

    // Datapath next state: load on accept, iterate in CALC
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        if (state_q == S_IDLE && accept) begin
            op_d    = op3;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            cnt_d   = '0;
            res_d   = spec_res;
            if (is_div) begin
                opnd_d = b_mag;
                acc_d  = {{XLEN{1'b0}}, a_mag};
            end else begin
                opnd_d = a_mag;
                acc_d  = {{XLEN{1'b0}}, b_mag};
            end
        end else if (state_q == S_CALC) begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST)
                res_d = fin_res;
        end
    end

    // Datapath registers with synchronous clear
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            op_q    <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_i)
                    state_d = S_IDLE;
                else if (cnt_q == LAST)
                    state_d = S_DONE;
            end
            S_DONE: if (flush_i || ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; result is gated to zero outside DONE
    always_comb begin
        ready_o  = (state_q == S_IDLE);
        valid_o  = (state_q == S_DONE);
        busy_o   = (state_q != S_IDLE);
        result_o = (state_q == S_DONE) ? res_q : '0;
    end

endmodule
